// File: rtl/onehot_scan_dec.sv
// onehot_scan_dec
//   Registered binary-to-one-hot decoder with a direct mode and an auto-scan
//   mode. Direct mode decodes sel. Auto-scan mode uses a prescaled counter to
//   walk the asserted bit across all channels, with optional blanking after
//   each step. Used for display anodes, row strobes and chip-selects.
//
// Ports
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : 1 = decoder active, 0 = all outputs inactive
//   mode  : 0 = direct decode of sel, 1 = auto-scan
//   sel   : channel select (direct mode)
//   out   : registered one-hot, polarity set by ACTIVE_LOW
//   idx   : channel currently driven (registered sel or scan counter)
//   tick  : one-cycle pulse after each auto-scan advance
//   err   : registered; 1 when a direct-mode sel is >= N_OUT
module onehot_scan_dec #(
  parameter int SEL_W      = 3,
  parameter int N_OUT      = 8,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int PRESCALE   = 4,
  parameter int BLANK      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             tick,
  output logic             err
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  localparam logic [N_OUT-1:0] INACTIVE = ACTIVE_LOW ? {N_OUT{1'b1}} : {N_OUT{1'b0}};
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0]  BL_LOAD  = BL_W'(BLANK);

  logic [PS_W-1:0]  psc;
  logic [PS_W-1:0]  psc_nxt;
  logic [BL_W-1:0]  blank_cnt;
  logic [BL_W-1:0]  blank_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [N_OUT-1:0] out_nxt;
  logic             tick_nxt;
  logic             err_nxt;
  logic             advance;
  logic             idx_in_range;
  logic             idx_last;

  // An out-of-range index leaves every bit deasserted, which after the
  // polarity flip is exactly the inactive pattern.
  function automatic logic [N_OUT-1:0] decode(input logic [SEL_W-1:0] k);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      v[i] = (int'(k) == i);
    end
    return ACTIVE_LOW ? ~v : v;
  endfunction

  always_comb begin
    advance      = (psc == PS_LAST);
    idx_in_range = (int'(idx) < N_OUT);
    idx_last     = (int'(idx) == N_OUT - 1);

    psc_nxt   = '0;
    blank_nxt = blank_cnt;
    idx_nxt   = idx;
    tick_nxt  = 1'b0;
    err_nxt   = 1'b0;
    out_nxt   = INACTIVE;

    if (en) begin
      if (!mode) begin
        // Direct mode keeps the prescaler and blank counter cleared, so a
        // switch into auto-scan always starts a fresh step period.
        idx_nxt   = sel;
        err_nxt   = (int'(sel) >= N_OUT);
        blank_nxt = '0;
        out_nxt   = decode(sel);
      end else begin
        psc_nxt = advance ? '0 : psc + 1'b1;

        // An index left over from direct mode may be out of range.
        if (!idx_in_range) begin
          idx_nxt = '0;
        end else if (advance) begin
          idx_nxt = idx_last ? '0 : idx + 1'b1;
        end

        if (advance) begin
          tick_nxt  = 1'b1;
          blank_nxt = BL_LOAD;
        end else if (blank_cnt != '0) begin
          blank_nxt = blank_cnt - 1'b1;
        end

        // Decoding the next index makes the switch on an advance edge clean:
        // the old bit drops in the same cycle the new one rises.
        out_nxt = (blank_nxt != '0) ? INACTIVE : decode(idx_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc       <= '0;
      blank_cnt <= '0;
      idx       <= '0;
      out       <= INACTIVE;
      tick      <= 1'b0;
      err       <= 1'b0;
    end else begin
      psc       <= psc_nxt;
      blank_cnt <= blank_nxt;
      idx       <= idx_nxt;
      out       <= out_nxt;
      tick      <= tick_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_scan_dec.sv
// tb_onehot_scan_dec
//   Three decoder instances share one stimulus stream:
//     d8 : SEL_W=3, N_OUT=8, active-high, PRESCALE=4, BLANK=0
//     d5 : SEL_W=3, N_OUT=5, active-high, PRESCALE=4, BLANK=2
//     d4 : SEL_W=2, N_OUT=4, active-low,  PRESCALE=4, BLANK=0
//   Stimulus pushes expected responses tagged with the cycle they must appear
//   in; an independent monitor pops and compares them on the falling edge.
module tb_onehot_scan_dec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] sel;

  logic [7:0] d8_out;
  logic [2:0] d8_idx;
  logic       d8_tick, d8_err;
  logic [4:0] d5_out;
  logic [2:0] d5_idx;
  logic       d5_tick, d5_err;
  logic [3:0] d4_out;
  logic [1:0] d4_idx;
  logic       d4_tick, d4_err;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         inst;
    logic [7:0] out;
    logic [2:0] idx;
    logic       tick;
    logic       err;
  } exp_t;

  exp_t sb[$];

  // Direct sweep, sel = 0..7
  localparam logic [7:0] SW8O [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  localparam logic [7:0] SW5O [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h00, 8'h00};
  localparam logic       SW5E [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [7:0] SW4O [8] = '{8'h0E, 8'h0D, 8'h0B, 8'h07, 8'h0E, 8'h0D, 8'h0B, 8'h07};

  // Auto scan from idx=0, results after edges k = 1..27
  localparam logic [7:0] A8O [27] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02,
                                      8'h04, 8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08,
                                      8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20,
                                      8'h40, 8'h40, 8'h40, 8'h40};
  localparam logic [2:0] A8I [27] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                      3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                                      3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5,
                                      3'd6, 3'd6, 3'd6, 3'd6};
  localparam logic [7:0] A5O [27] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h02,
                                      8'h00, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h08, 8'h08,
                                      8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h01, 8'h01,
                                      8'h00, 8'h00, 8'h02, 8'h02};
  localparam logic [2:0] A5I [27] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                      3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                                      3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0,
                                      3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [7:0] A4O [27] = '{8'h0E, 8'h0E, 8'h0E, 8'h0D, 8'h0D, 8'h0D, 8'h0D,
                                      8'h0B, 8'h0B, 8'h0B, 8'h0B, 8'h07, 8'h07, 8'h07, 8'h07,
                                      8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0D, 8'h0D, 8'h0D, 8'h0D,
                                      8'h0B, 8'h0B, 8'h0B, 8'h0B};
  localparam logic [2:0] A4I [27] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                      3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                                      3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                      3'd2, 3'd2, 3'd2, 3'd2};
  localparam logic       ATK [27] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b0, 1'b0};

  onehot_scan_dec #(.SEL_W(3), .N_OUT(8), .ACTIVE_LOW(1'b0), .PRESCALE(4), .BLANK(0)) d8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .out(d8_out), .idx(d8_idx), .tick(d8_tick), .err(d8_err)
  );

  onehot_scan_dec #(.SEL_W(3), .N_OUT(5), .ACTIVE_LOW(1'b0), .PRESCALE(4), .BLANK(2)) d5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .out(d5_out), .idx(d5_idx), .tick(d5_tick), .err(d5_err)
  );

  onehot_scan_dec #(.SEL_W(2), .N_OUT(4), .ACTIVE_LOW(1'b1), .PRESCALE(4), .BLANK(0)) d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]),
    .out(d4_out), .idx(d4_idx), .tick(d4_tick), .err(d4_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int inst, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", name, inst, cyc, act, req);
    end
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] a_out;
    logic [2:0] a_idx;
    logic       a_tick;
    logic       a_err;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL stale_expectation inst=%0d due=%0d now=%0d", e.inst, e.cyc, cyc);
      end
      case (e.inst)
        0: begin
          a_out = d8_out; a_idx = d8_idx; a_tick = d8_tick; a_err = d8_err;
        end
        1: begin
          a_out = {3'b000, d5_out}; a_idx = d5_idx; a_tick = d5_tick; a_err = d5_err;
        end
        default: begin
          a_out = {4'b0000, d4_out}; a_idx = {1'b0, d4_idx}; a_tick = d4_tick; a_err = d4_err;
        end
      endcase
      cmp("out",  e.inst, a_out, e.out);
      cmp("idx",  e.inst, {5'b0, a_idx}, {5'b0, e.idx});
      cmp("tick", e.inst, {7'b0, a_tick}, {7'b0, e.tick});
      cmp("err",  e.inst, {7'b0, a_err}, {7'b0, e.err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int dc, input int inst, input logic [7:0] o,
                      input logic [2:0] i, input logic t, input logic e);
    exp_t x;
    x.cyc  = cyc + dc;
    x.inst = inst;
    x.out  = o;
    x.idx  = i;
    x.tick = t;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic push_all(input int dc,
                          input logic [7:0] o8, input logic [2:0] i8,
                          input logic [7:0] o5, input logic [2:0] i5, input logic e5,
                          input logic [7:0] o4, input logic [2:0] i4,
                          input logic t);
    push(dc, 0, o8, i8, t, 1'b0);
    push(dc, 1, o5, i5, t, e5);
    push(dc, 2, o4, i4, t, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = 3'd0;

    // Reset values
    step();
    push_all(0, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0, 8'h0F, 3'd0, 1'b0);
    step();

    // Direct sweep, one-cycle latency; d5 flags sel >= 5
    rst_n = 1'b1;
    en    = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      push_all(1, SW8O[s], 3'(s), SW5O[s], 3'(s), SW5E[s], SW4O[s], 3'(s % 4), 1'b0);
      step();
    end

    // en=0: outputs inactive, idx held, err cleared
    en = 1'b0;
    push_all(1, 8'h00, 3'd7, 8'h00, 3'd7, 1'b0, 8'h0F, 3'd3, 1'b0);
    step();

    // Out of range then back in range
    en  = 1'b1;
    sel = 3'd6;
    push_all(1, 8'h40, 3'd6, 8'h00, 3'd6, 1'b1, 8'h0B, 3'd2, 1'b0);
    step();
    sel = 3'd2;
    push_all(1, 8'h04, 3'd2, 8'h04, 3'd2, 1'b0, 8'h0B, 3'd2, 1'b0);
    step();
    sel = 3'd0;
    push_all(1, 8'h01, 3'd0, 8'h01, 3'd0, 1'b0, 8'h0E, 3'd0, 1'b0);
    step();

    // Auto scan from idx=0: advances at edges 4, 8, 12, ...
    mode = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      push_all(k, A8O[k-1], A8I[k-1], A5O[k-1], A5I[k-1], 1'b0, A4O[k-1], A4I[k-1], ATK[k-1]);
    end
    repeat (27) step();

    // Reset while d5 has just advanced to idx=2 and is blanking, tick high
    step();
    rst_n = 1'b0;
    push_all(0, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0, 8'h0F, 3'd0, 1'b0);
    step();
    step();

    // After release the first advance is PRESCALE edges later
    rst_n = 1'b1;
    push_all(3, 8'h01, 3'd0, 8'h01, 3'd0, 1'b0, 8'h0E, 3'd0, 1'b0);
    push_all(4, 8'h02, 3'd1, 8'h00, 3'd1, 1'b0, 8'h0D, 3'd1, 1'b1);
    repeat (4) step();

    // Leave an out-of-range idx in d5, then re-enter auto: idx restarts at 0
    mode = 1'b0;
    sel  = 3'd6;
    push_all(1, 8'h40, 3'd6, 8'h00, 3'd6, 1'b1, 8'h0B, 3'd2, 1'b0);
    step();
    mode = 1'b1;
    push_all(1, 8'h40, 3'd6, 8'h01, 3'd0, 1'b0, 8'h0B, 3'd2, 1'b0);
    step();

    // Drain, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      failures += sb.size();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_scan_dec.md
# onehot_scan_dec

Parametrised, registered binary-to-one-hot decoder with two modes. In direct mode it decodes an external select. In auto-scan mode an internal prescaled counter walks the one-hot output across all channels, with optional blanking between steps. It drives display anodes, row strobes and chip-selects on the Basys3 top level, and generalises the 3-to-8 decoder to any width, selectable polarity and time-multiplexed scanning.

## Interface
- SEL_W, 3, select/index width; legal 1..8
- N_OUT, 8, number of one-hot outputs; legal 2..2**SEL_W
- ACTIVE_LOW, 0, 1 = asserted output bit is 0 (Basys3 anodes), inactive bits are 1
- PRESCALE, 4, clk cycles per scan step in auto mode; legal >= 1
- BLANK, 0, cycles all outputs are inactive after each scan step; legal 0..PRESCALE-1
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  1 = decoder active; 0 = all outputs inactive
- mode  input  1  0 = direct decode of sel; 1 = auto-scan
- sel  input  SEL_W  channel select, used in direct mode
- out  output  N_OUT  registered one-hot (polarity per ACTIVE_LOW)
- idx  output  SEL_W  channel currently driven (direct: registered sel; auto: scan counter)
- tick  output  1  one-cycle pulse when auto-scan advances idx
- err  output  1  registered; 1 when direct-mode sel >= N_OUT

## Operation
- "Inactive" means all bits 0, or all bits 1 if ACTIVE_LOW=1. "One-hot(k)" means only bit k is asserted.
- Reset values (async, while rst_n=0):
  - out = inactive
  - idx = 0, tick = 0, err = 0
  - prescaler = 0, blank counter = 0
- Reset release takes effect on the first rising clk edge with rst_n=1.
- en=0:
  - out = inactive, tick = 0, err = 0
  - prescaler held at 0
  - idx and blank counter hold their values
- Direct mode (en=1, mode=0), per edge:
  - idx <= sel
  - If sel < N_OUT: out <= one-hot(sel), err <= 0.
  - If sel >= N_OUT: out <= inactive, err <= 1.
  - Prescaler held at 0; tick = 0.
- Auto mode (en=1, mode=1):
  - err = 0 throughout.
  - Prescaler counts 0..PRESCALE-1, then wraps to 0.
  - On the edge where prescaler = PRESCALE-1:
    - idx <= (idx == N_OUT-1) ? 0 : idx+1
    - tick <= 1 for one cycle
    - blank counter <= BLANK
  - out <= inactive while the blank counter is nonzero; the counter decrements each edge.
  - Otherwise out <= one-hot(idx).
- Entering auto mode with idx >= N_OUT (left over from direct mode): idx <= 0 on the first auto edge.
- Mode change, either direction: prescaler clears to 0 on that edge and the blank counter clears. Auto-scan resumes from the current idx.
- Width rules:
  - Prescaler width is clog2(PRESCALE), minimum 1.
  - Blank counter width is clog2(BLANK+1), minimum 1.
  - No output bit is indexed beyond N_OUT-1.

## Timing
- All outputs are registered; no combinational path from input to output.
- Direct latency is one cycle: sel sampled at edge k appears on out/idx/err after edge k.
- Auto mode with mode held at 1, starting from a cleared prescaler:
  - idx advances at edges P, 2P, 3P... (P = PRESCALE).
  - tick is high for the cycle following each advance edge.
- With BLANK=B > 0: after an advance edge, out is inactive for exactly B cycles, then shows one-hot(new idx).
- With BLANK=0: out switches directly from the old one-hot to the new one on the advance edge, so no cycle has two bits asserted.
- en toggling 1→0: out goes inactive after the next edge. On en 0→1, the prescaler restarts from 0.
- Reset mid-blank or mid-prescale: everything returns to reset values immediately (async), with no glitch pulse on tick.

## Test plan
- Direct sweep, SEL_W=3, N_OUT=8, ACTIVE_LOW=0: sel=0..7, one value per cycle -> out=8'h01,02,04,...,80, one cycle late; idx=sel; err=0.
- Out of range, N_OUT=5: sel=6 -> out=5'b00000, err=1 next cycle; sel=2 -> out=5'b00100, err=0.
- Polarity, ACTIVE_LOW=1, N_OUT=4: sel=1 -> out=4'b1101; en=0 -> out=4'b1111 after one edge.
- Auto wrap, N_OUT=4, PRESCALE=4, BLANK=0: mode=1 from idx=0 -> idx 1,2,3,0 at edges 4,8,12,16; tick high one cycle after each; out=0001→0010→0100→1000→0001.
- Blanking, PRESCALE=4, BLANK=2: at each advance -> out=0000 for 2 cycles, then one-hot(new idx) for 2 cycles; no cycle with more than one bit asserted.
- Reset mid-scan: drop rst_n while idx=2 and blank is active -> out inactive, idx=0, tick=0 immediately; after release, the first advance comes PRESCALE edges later.
